wb_select_stage: RTL and testbench

Registered writeback stage for the pipelined core: selects the register-file write value from NSRC result sources, aligns and sign/zero-extends load data, and holds the pipe when load data returns late. It sits between the memory stage and the register-file write port. It replaces the purely combinational result select with a valid/ready handshake, flush support and a defined value for every select code.

---
 rtl/wb_select_stage.sv | 177 +++++++++++++++++
 tb/tb_wb_select_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
// Registered writeback stage: picks the register-file write value from NSRC sources,
// formats load data, and stalls in WAIT_LOAD when load data arrives after acceptance.
module wb_select_stage #(
  parameter  int XLEN     = 32,
  parameter  int NSRC     = 4,
  parameter  int LOAD_IDX = 2,
  localparam int SELW     = $clog2(NSRC),
  localparam int LOW      = $clog2(XLEN/8)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      wb_sel,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [4:0]           rd_addr,
  input  logic                 reg_write,
  input  logic [1:0]           load_size,
  input  logic                 load_unsigned,
  input  logic [LOW-1:0]       addr_lo,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 flush,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [4:0]           wb_addr,
  output logic [XLEN-1:0]      wb_data
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [LOW-1:0]  alo_q, alo_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic [XLEN-1:0] sel_data;
  logic            sel_legal;
  logic            is_load;
  logic            ret;
  logic            ret_rw;
  logic [4:0]      ret_addr;
  logic [XLEN-1:0] ret_data;

  // Lane offset is the address with the sub-lane bits cleared; full-width loads never shift.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] rdata,
                                               input logic [1:0]      size,
                                               input logic            uns,
                                               input logic [LOW-1:0]  alo);
    logic [LOW-1:0]  off;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    case (size)
      2'b00:   off = alo;
      2'b01:   off = alo & ~LOW'(1);
      2'b10:   off = alo & ~LOW'(3);
      default: off = '0;
    endcase
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   res = uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'b01:   res = uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'b10:   res = uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: res = sh;
    endcase
    return res;
  endfunction

  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (wb_sel == SELW'(k)) begin
        sel_data  = src_data[k*XLEN +: XLEN];
        sel_legal = 1'b1;
      end
    end
  end

  assign is_load = (wb_sel == SELW'(LOAD_IDX));

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    size_d     = size_q;
    uns_d      = uns_q;
    alo_d      = alo_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    ret        = 1'b0;
    ret_rw     = reg_write;
    ret_addr   = rd_addr;
    ret_data   = sel_data;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (is_load) begin
            if (mem_rvalid) begin
              ret      = 1'b1;
              ret_data = fmt_load(mem_rdata, load_size, load_unsigned, addr_lo);
            end else begin
              rd_d    = rd_addr;
              rw_d    = reg_write;
              size_d  = load_size;
              uns_d   = load_unsigned;
              alo_d   = addr_lo;
              state_d = WAIT_LOAD;
            end
          end else begin
            ret    = 1'b1;
            ret_rw = reg_write && sel_legal;
          end
        end
      end
      WAIT_LOAD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          ret      = 1'b1;
          ret_rw   = rw_q;
          ret_addr = rd_q;
          ret_data = fmt_load(mem_rdata, size_q, uns_q, alo_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ret) begin
      wb_valid_d = 1'b1;
      wb_we_d    = ret_rw && (ret_addr != 5'd0);
      wb_addr_d  = ret_addr;
      wb_data_d  = ret_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      alo_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      alo_q      <= alo_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: three instances (32b/4 sources, 32b/3 sources,
// 64b/4 sources) checked every cycle against a scoreboard of expected writebacks.
module tb_wb_select_stage;

  typedef struct packed {
    logic [1:0]  dut;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid_v;
  logic [1:0]   wb_sel;
  logic [4:0]   rd_addr;
  logic         reg_write;
  logic [1:0]   load_size;
  logic         load_unsigned;
  logic [2:0]   addr_lo;
  logic         mem_rvalid;
  logic         flush;
  logic [127:0] src32;
  logic [255:0] src64;
  logic [31:0]  rdata32;
  logic [63:0]  rdata64;

  logic [2:0]   in_ready_v;
  logic [2:0]   wb_valid_v;
  logic [2:0]   wb_we_v;
  logic [4:0]   wb_addr0, wb_addr1, wb_addr2;
  logic [31:0]  wb_data0, wb_data1;
  logic [63:0]  wb_data2;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  wb_select_stage #(.XLEN(32), .NSRC(4), .LOAD_IDX(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .wb_sel(wb_sel), .src_data(src32), .rd_addr(rd_addr), .reg_write(reg_write),
    .load_size(load_size), .load_unsigned(load_unsigned), .addr_lo(addr_lo[1:0]),
    .mem_rvalid(mem_rvalid), .mem_rdata(rdata32), .flush(flush),
    .wb_valid(wb_valid_v[0]), .wb_we(wb_we_v[0]), .wb_addr(wb_addr0), .wb_data(wb_data0));

  wb_select_stage #(.XLEN(32), .NSRC(3), .LOAD_IDX(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .wb_sel(wb_sel), .src_data(src32[95:0]), .rd_addr(rd_addr), .reg_write(reg_write),
    .load_size(load_size), .load_unsigned(load_unsigned), .addr_lo(addr_lo[1:0]),
    .mem_rvalid(mem_rvalid), .mem_rdata(rdata32), .flush(flush),
    .wb_valid(wb_valid_v[1]), .wb_we(wb_we_v[1]), .wb_addr(wb_addr1), .wb_data(wb_data1));

  wb_select_stage #(.XLEN(64), .NSRC(4), .LOAD_IDX(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .wb_sel(wb_sel), .src_data(src64), .rd_addr(rd_addr), .reg_write(reg_write),
    .load_size(load_size), .load_unsigned(load_unsigned), .addr_lo(addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(rdata64), .flush(flush),
    .wb_valid(wb_valid_v[2]), .wb_we(wb_we_v[2]), .wb_addr(wb_addr2), .wb_data(wb_data2));

  function automatic logic [4:0] obs_addr(input int d);
    case (d)
      0:       return wb_addr0;
      1:       return wb_addr1;
      default: return wb_addr2;
    endcase
  endfunction

  function automatic logic [63:0] obs_data(input int d);
    case (d)
      0:       return {32'h0, wb_data0};
      1:       return {32'h0, wb_data1};
      default: return wb_data2;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectWb(input int d, input logic we, input logic [4:0] addr, input logic [63:0] data);
    exp_t e;
    e.dut  = 2'(d);
    e.we   = we;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Expectations queued before an edge must show up right after that edge, and nothing else may pulse.
  task automatic step();
    exp_t pend[$];
    pend = sb_q;
    sb_q.delete();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      logic hit;
      exp_t e;
      hit = 1'b0;
      e   = '0;
      foreach (pend[i]) begin
        if (pend[i].dut == 2'(d)) begin
          hit = 1'b1;
          e   = pend[i];
        end
      end
      checkOutput($sformatf("wb_valid[%0d]", d), 64'(wb_valid_v[d]), 64'(hit));
      if (hit) begin
        checkOutput($sformatf("wb_we[%0d]", d), 64'(wb_we_v[d]), 64'(e.we));
        checkOutput($sformatf("wb_addr[%0d]", d), 64'(obs_addr(d)), 64'(e.addr));
        checkOutput($sformatf("wb_data[%0d]", d), obs_data(d), e.data);
      end
    end
  endtask

  task automatic applyStimulus(input int d, input logic [1:0] sel, input logic [4:0] rd,
                               input logic rw, input logic [1:0] size, input logic uns,
                               input logic [2:0] alo, input logic rv, input logic fl,
                               input logic exp_wb, input logic exp_we, input logic [63:0] exp_data);
    in_valid_v    = '0;
    in_valid_v[d] = 1'b1;
    wb_sel        = sel;
    rd_addr       = rd;
    reg_write     = rw;
    load_size     = size;
    load_unsigned = uns;
    addr_lo       = alo;
    mem_rvalid    = rv;
    flush         = fl;
    if (exp_wb) expectWb(d, exp_we, rd, exp_data);
    step();
  endtask

  task automatic idle();
    in_valid_v = '0;
    mem_rvalid = 1'b0;
    flush      = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_v = '0; wb_sel = '0; rd_addr = '0; reg_write = 1'b0;
    load_size = '0; load_unsigned = 1'b0; addr_lo = '0; mem_rvalid = 1'b0; flush = 1'b0;
    src32   = {32'hCCCC_0003, 32'h5555_AAAA, 32'h0000_1234, 32'h0000_0004};
    src64   = {64'h0, 64'h0, 64'h1122_3344_5566_7788, 64'h0};
    rdata32 = '0;
    rdata64 = '0;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("rst_valid[%0d]", d), 64'(wb_valid_v[d]), 64'd0);
      checkOutput($sformatf("rst_we[%0d]", d), 64'(wb_we_v[d]), 64'd0);
      checkOutput($sformatf("rst_addr[%0d]", d), 64'(obs_addr(d)), 64'd0);
      checkOutput($sformatf("rst_data[%0d]", d), obs_data(d), 64'd0);
      checkOutput($sformatf("rst_ready[%0d]", d), 64'(in_ready_v[d]), 64'd1);
    end
    rst_n = 1'b1;
    step();

    // ALU op, then the outputs hold while idle
    applyStimulus(0, 2'd1, 5'd5, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1234);
    idle();
    checkOutput("hold_addr", 64'(wb_addr0), 64'd5);
    checkOutput("hold_data", obs_data(0), 64'h1234);

    // same-cycle byte loads, back to back
    rdata32 = 32'h80FF_7F01;
    applyStimulus(0, 2'd2, 5'd6, 1'b1, 2'b00, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FF80);
    applyStimulus(0, 2'd2, 5'd6, 1'b1, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h7F);
    rdata32 = 32'h8000_0001;
    applyStimulus(0, 2'd2, 5'd6, 1'b1, 2'b11, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0001);
    idle();

    // late half load; live inputs change while waiting so only captured fields can give the answer
    applyStimulus(0, 2'd2, 5'd7, 1'b1, 2'b01, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("wait_ready_1", 64'(in_ready_v[0]), 64'd0);
    wb_sel = 2'd1; rd_addr = 5'd3; load_size = 2'b00; load_unsigned = 1'b1; addr_lo = 3'd0;
    rdata32 = 32'hBEEF_0000;
    step();
    checkOutput("wait_ready_2", 64'(in_ready_v[0]), 64'd0);
    step();
    checkOutput("wait_ready_3", 64'(in_ready_v[0]), 64'd0);
    mem_rvalid = 1'b1;
    expectWb(0, 1'b1, 5'd7, 64'hFFFF_BEEF);
    step();
    checkOutput("late_ready", 64'(in_ready_v[0]), 64'd1);
    idle();

    // flush beats mem_rvalid in WAIT_LOAD
    applyStimulus(0, 2'd2, 5'd8, 1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    in_valid_v = '0; flush = 1'b1; mem_rvalid = 1'b1; rdata32 = 32'h1122_3344;
    step();
    checkOutput("flush_wait_ready", 64'(in_ready_v[0]), 64'd1);
    in_valid_v = '0; flush = 1'b0; mem_rvalid = 1'b1;
    step();
    idle();

    // flush in IDLE: neither an ALU op nor a late load is taken
    applyStimulus(0, 2'd1, 5'd9, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    applyStimulus(0, 2'd2, 5'd9, 1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("flush_idle_ready", 64'(in_ready_v[0]), 64'd1);
    idle();

    // rd=0, reg_write=0, unused select on the 3-source instance
    applyStimulus(0, 2'd1, 5'd0, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1234);
    applyStimulus(0, 2'd3, 5'd4, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hCCCC_0003);
    idle();
    applyStimulus(1, 2'd3, 5'd9, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    applyStimulus(1, 2'd0, 5'd10, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h4);
    idle();

    // four back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      src32[63:32] = 32'h1000 + 32'(i);
      applyStimulus(0, 2'd1, 5'(11 + i), 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1,
                    64'h1000 + 64'(i));
    end
    idle();

    // 64-bit instance: word, byte, half, dword loads and an ALU op
    rdata64 = 64'h8000_0000_0000_0000;
    applyStimulus(2, 2'd2, 5'd12, 1'b1, 2'b10, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    rdata64 = 64'hA500_0000_0000_0000;
    applyStimulus(2, 2'd2, 5'd12, 1'b1, 2'b00, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 64'hA5);
    rdata64 = 64'h8001_0000_0000_0000;
    applyStimulus(2, 2'd2, 5'd12, 1'b1, 2'b01, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
    rdata64 = 64'hDEAD_BEEF_0123_4567;
    applyStimulus(2, 2'd2, 5'd12, 1'b1, 2'b11, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    applyStimulus(2, 2'd1, 5'd13, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1122_3344_5566_7788);
    idle();

    // reset while waiting on a load aborts it
    applyStimulus(0, 2'd2, 5'd14, 1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    in_valid_v = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wait_ready", 64'(in_ready_v[0]), 64'd1);
    checkOutput("rst_wait_data", obs_data(0), 64'd0);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    step();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
